// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM states and iteration count for the RV32M multiply/divide unit.
package muldiv_pkg;
  typedef enum logic [2:0] {MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU} muldiv_op_e;
  typedef enum logic [1:0] {IDLE, CALC, FIN} muldiv_state_e;
  localparam int MULDIV_ITER = 32;
endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: core-side request/response bundle of the multiply/divide unit.
interface muldiv_if #(parameter int XLEN = 32);
  logic start;
  logic kill;
  logic [2:0] op;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [4:0] rd_in;
  logic busy;
  logic done;
  logic [XLEN-1:0] result;
  logic [4:0] rd_out;
  modport master(output start, kill, op, rs1_data, rs2_data, rd_in, input busy, done, result, rd_out);
  modport slave(input start, kill, op, rs1_data, rs2_data, rd_in, output busy, done, result, rd_out);
endinterface

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: restores operand signs on the magnitude result and selects the architectural word.
module muldiv_sign_fix import muldiv_pkg::*; #(parameter int XLEN = 32) (
  input  muldiv_op_e op,
  input  logic [2*XLEN-1:0] acc,
  input  logic neg_a,
  input  logic neg_b,
  output logic [XLEN-1:0] result
);
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0] rem;
  always_comb begin
    prod = (neg_a ^ neg_b) ? -acc : acc;
    rem = neg_a ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    result = op[2] ? (op[1] ? rem : prod[XLEN-1:0])
                   : (op == MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M shift-add multiplier / restoring divider sharing one 64-bit register.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle combinational one.
module muldiv_unit import muldiv_pkg::*; #(parameter int XLEN = 32) (
  input logic clk,
  input logic rst_n,
  muldiv_if.slave bus
);
  muldiv_state_e state, state_nx;
  muldiv_op_e op_q;
  logic [4:0] cnt, rd_q;
  logic [XLEN-1:0] b_q, abs_a, abs_b, fixed;
  logic [2*XLEN-1:0] acc, acc_nx, acc_init, fast_prod;
  logic [XLEN:0] mul_sum, div_diff;
  logic neg_a, neg_b, is_div, a_sgn, b_sgn, div_zero, ovf, fast, special, accept;

  assign is_div = bus.op[2];
  assign a_sgn = bus.op == MULH || bus.op == MULHSU || bus.op == DIV || bus.op == REM;
  assign b_sgn = bus.op == MULH || bus.op == DIV || bus.op == REM;
  assign abs_a = (a_sgn && bus.rs1_data[XLEN-1]) ? -bus.rs1_data : bus.rs1_data;
  assign abs_b = (b_sgn && bus.rs2_data[XLEN-1]) ? -bus.rs2_data : bus.rs2_data;
  assign div_zero = is_div && bus.rs2_data == '0;
  assign ovf = (bus.op == DIV || bus.op == REM) && &bus.rs2_data
               && bus.rs1_data == {1'b1, {(XLEN-1){1'b0}}};

`ifdef MULDIV_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fa, fb;
  assign fa = {{XLEN{a_sgn & bus.rs1_data[XLEN-1]}}, bus.rs1_data};
  assign fb = {{XLEN{b_sgn & bus.rs2_data[XLEN-1]}}, bus.rs2_data};
  assign fast_prod = fa * fb;
  assign fast = !is_div;
`else
  assign fast_prod = '0;
  assign fast = 1'b0;
`endif

  assign special = div_zero || ovf || fast;
  assign accept = state == IDLE && bus.start && !bus.kill;
  assign bus.busy = state != IDLE;

  // Early-finishing ops preload the final value with clear sign flags so FIN passes it through.
  assign acc_init = div_zero ? {bus.rs1_data, {XLEN{1'b1}}}
                  : ovf ? {{XLEN{1'b0}}, 1'b1, {(XLEN-1){1'b0}}}
                  : fast ? fast_prod
                  : {{XLEN{1'b0}}, is_div ? abs_a : abs_b};

  // Multiply: {hi, multiplier} shifts right; divide: {rem, dividend} shifts left, quotient bits enter at lsb.
  assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_q} : '0);
  assign div_diff = acc[2*XLEN-1:XLEN-1] - {1'b0, b_q};
  assign acc_nx = !op_q[2] ? {mul_sum, acc[XLEN-1:1]}
                : div_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                : {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};

  always_comb begin
    state_nx = state;
    if (state == FIN || (state == CALC && bus.kill)) state_nx = IDLE;
    else if (accept) state_nx = special ? FIN : CALC;
    else if (state == CALC && cnt == 5'(MULDIV_ITER - 1)) state_nx = FIN;
  end

  muldiv_sign_fix #(.XLEN(XLEN)) u_fix (
    .op(op_q), .acc(acc), .neg_a(neg_a), .neg_b(neg_b), .result(fixed)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      op_q <= MUL;
      rd_q <= '0;
      b_q <= '0;
      acc <= '0;
      neg_a <= 1'b0;
      neg_b <= 1'b0;
      bus.done <= 1'b0;
      bus.result <= '0;
      bus.rd_out <= '0;
    end else begin
      state <= state_nx;
      bus.done <= 1'b0;
      if (accept) begin
        op_q <= muldiv_op_e'(bus.op);
        rd_q <= bus.rd_in;
        b_q <= is_div ? abs_b : abs_a;
        acc <= acc_init;
        neg_a <= a_sgn && bus.rs1_data[XLEN-1] && !special;
        neg_b <= b_sgn && bus.rs2_data[XLEN-1] && !special;
        cnt <= '0;
      end
      if (state == CALC) begin
        acc <= acc_nx;
        cnt <= cnt + 5'd1;
      end
      if (state == FIN && !bus.kill) begin
        bus.done <= 1'b1;
        bus.result <= fixed;
        bus.rd_out <= rd_q;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit (honours MULDIV_FAST_MUL_EN latency).
module tb_muldiv_unit;
  import muldiv_pkg::*;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 33;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_fail = 0;
  muldiv_if #(.XLEN(32)) bus();
  muldiv_unit dut(.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic run_op(input muldiv_op_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, output logic [31:0] res, output logic [4:0] rdo,
                        output int lat);
    bus.op = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in = rd;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    res = bus.result;
    rdo = bus.rd_out;
  endtask

  task automatic test_reset;
    bus.start = 1'b0;
    bus.kill = 1'b0;
    bus.op = 3'd0;
    bus.rs1_data = '0;
    bus.rs2_data = '0;
    bus.rd_in = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL reset_result got %h want 0", bus.result); end
    n_cmp++; if (bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd got %0d want 0", bus.rd_out); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul;
    logic [31:0] res; logic [4:0] rdo; int lat;
    run_op(MUL, 32'h7, 32'hFFFF_FFFD, 5'd7, res, rdo, lat);
    n_cmp++; if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result got %h want ffffffeb", res); end
    n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mul_latency got %0d want %0d", lat, MUL_LAT); end
    n_cmp++; if (rdo !== 5'd7) begin n_fail++; $display("FAIL mul_rd got %0d want 7", rdo); end
  endtask

  task automatic test_mulh;
    muldiv_op_e ops[3] = '{MULH, MULHU, MULHSU};
    logic [31:0] exp[3] = '{32'h0000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [31:0] res; logic [4:0] rdo; int lat;
    for (int i = 0; i < 3; i++) begin
      run_op(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, 5'(i + 1), res, rdo, lat);
      n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL mulh_%0d result got %h want %h", i, res, exp[i]); end
      n_cmp++; if (lat !== MUL_LAT) begin n_fail++; $display("FAIL mulh_%0d latency got %0d want %0d", i, lat, MUL_LAT); end
    end
  endtask

  task automatic test_div;
    muldiv_op_e ops[4] = '{DIV, REM, DIVU, REMU};
    logic [31:0] a[4] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    logic [31:0] b[4] = '{32'd2, 32'd2, 32'd7, 32'd7};
    logic [31:0] exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    logic [31:0] res; logic [4:0] rdo; int lat;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], a[i], b[i], 5'd10, res, rdo, lat);
      n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL div_%0d result got %h want %h", i, res, exp[i]); end
      n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL div_%0d latency got %0d want 33", i, lat); end
    end
  endtask

  task automatic test_div_special;
    muldiv_op_e ops[6] = '{DIV, REM, DIVU, REMU, DIV, REM};
    logic [31:0] a[6] = '{32'd5, 32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] b[6] = '{32'd0, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] exp[6] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0};
    logic [31:0] res; logic [4:0] rdo; int lat;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], a[i], b[i], 5'd11, res, rdo, lat);
      n_cmp++; if (res !== exp[i]) begin n_fail++; $display("FAIL special_%0d result got %h want %h", i, res, exp[i]); end
      n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL special_%0d latency got %0d want 1", i, lat); end
    end
  endtask

  task automatic test_kill;
    logic [31:0] res; logic [4:0] rdo; int lat; int seen;
    run_op(DIVU, 32'd100, 32'd7, 5'd2, res, rdo, lat);
    bus.op = REMU;
    bus.rd_in = 5'd20;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.kill = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_busy got %b want 0", bus.busy); end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_fail++; $display("FAIL kill_done got %0d pulses want 0", seen); end
    n_cmp++; if (bus.result !== 32'd14) begin n_fail++; $display("FAIL kill_result got %h want 0000000e", bus.result); end
    n_cmp++; if (bus.rd_out !== 5'd2) begin n_fail++; $display("FAIL kill_rd got %0d want 2", bus.rd_out); end
    bus.kill = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.kill = 1'b0;
    bus.start = 1'b0;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL kill_start_idle busy got %b want 0", bus.busy); end
  endtask

  task automatic test_start_busy;
    int lat;
    bus.op = DIVU;
    bus.rs1_data = 32'd100;
    bus.rs2_data = 32'd7;
    bus.rd_in = 5'd3;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    bus.op = MUL;
    bus.rs1_data = 32'd2;
    bus.rs2_data = 32'd2;
    bus.rd_in = 5'd4;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = -1;
    for (int i = 7; i <= 100; i++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL start_busy latency got %0d want 33", lat); end
    n_cmp++; if (bus.result !== 32'd14) begin n_fail++; $display("FAIL start_busy result got %h want 0000000e", bus.result); end
    n_cmp++; if (bus.rd_out !== 5'd3) begin n_fail++; $display("FAIL start_busy rd got %0d want 3", bus.rd_out); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    bus.op = DIVU;
    bus.rs1_data = 32'd50;
    bus.rs2_data = 32'd3;
    bus.rd_in = 5'd9;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (8) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.result !== 32'h0) begin n_fail++; $display("FAIL rstmid_result got %h want 0", bus.result); end
    n_cmp++; if (bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL rstmid_rd got %0d want 0", bus.rd_out); end
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done got %b want 0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    logic [31:0] res; logic [4:0] rdo; int lat;
    run_op(DIV, 32'd5, 32'd0, 5'd5, res, rdo, lat);
    n_cmp++; if (rdo !== 5'd5) begin n_fail++; $display("FAIL b2b_first rd got %0d want 5", rdo); end
    run_op(DIVU, 32'd100, 32'd7, 5'd12, res, rdo, lat);
    n_cmp++; if (lat !== 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", lat); end
    n_cmp++; if (res !== 32'd14) begin n_fail++; $display("FAIL b2b_result got %h want 0000000e", res); end
    n_cmp++; if (rdo !== 5'd12) begin n_fail++; $display("FAIL b2b_rd got %0d want 12", rdo); end
    @(posedge clk); #1;
    n_cmp++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse got %b want 0", bus.done); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_mulh;
    test_div;
    test_div_special;
    test_kill;
    test_start_busy;
    test_reset_mid;
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide execution unit in the monocycle datapath, between the register file read ports and its write port. Takes both source operands, op code and destination index, computes over multiple cycles while holding the core stalled via `busy`, then presents the result and destination index for a one-cycle register write. Shift-add multiplier and restoring divider share one 64-bit working register and one iteration counter.

## Interface
- `XLEN`, default 32: operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request; sampled only in IDLE
- `kill`  in  1  synchronous abort of an in-flight operation
- `op`  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- `rs1_data`  in  XLEN  operand A (dividend / multiplicand)
- `rs2_data`  in  XLEN  operand B (divisor / multiplier)
- `rd_in`  in  5  destination register index
- `busy`  out  1  operation in flight; core must stall
- `done`  out  1  one-cycle pulse; result valid and drives register write enable
- `result`  out  XLEN  result; held until next accepted start
- `rd_out`  out  5  destination captured at accept

## Operation
- States: IDLE, CALC, FIN.
- IDLE + `start`: latch op, rd, operands (absolute values for signed ops, operand signs recorded); counter=0; go CALC. Special cases go straight to FIN without iterating.
- Special cases (detected at accept): divisor 0 → DIV/DIVU = all ones, REM/REMU = rs1; DIV with rs1=0x8000_0000, rs2=0xFFFF_FFFF → quotient 0x8000_0000, REM → 0.
- CALC: one iteration per cycle; multiply = shift-add on 64-bit accumulator, divide = restoring shift-subtract; after iteration 31 (counter 31) go FIN.
- FIN: sign-correct (product negated if signs differ for MULH/MULHSU; quotient negated if signs differ; remainder takes sign of dividend); select low word (MUL, quotient, remainder) or high word (MULH*); register `result`, `rd_out`, `done`=1; go IDLE.
- MULHSU: only rs1 treated as signed. rd_in=0 is computed normally; register file discards the write.
- `kill` in CALC or FIN: go IDLE next edge, no `done`, `result`/`rd_out` unchanged. `kill` in IDLE: no effect; `kill` and `start` in IDLE together: start ignored.
- `start` while busy: ignored; operands not re-latched.

## Timing
- Reset: state IDLE, `busy`=0, `done`=0, `result`=0, `rd_out`=0, counter=0; reset mid-operation drops the operation silently.
- `busy` = state != IDLE (combinational from state register).
- Normal op: accept at edge E0; iterations E1–E32; E33 leaves FIN; `done` high in the cycle after E33 → 33-cycle latency.
- Special case: accept E0 → FIN; `done` high after E1 → 1-cycle latency.
- `done` is a single-cycle pulse; a new `start` in that same cycle is accepted (unit is IDLE).
- Counter 5 bits, wraps 31→0 only on leaving CALC.

## Configuration
- `MULDIV_FAST_MUL_EN` defined: MUL/MULH/MULHSU/MULHU use a single 33×33 signed combinational multiplier; accept E0 → FIN, `done` after E1 (1-cycle latency). Divides unchanged.
- Undefined: all multiplies iterate (33-cycle latency); no hardware multiplier inferred.

## Structure
- `muldiv_pkg`: `muldiv_op_e` (8 funct3 codes), `muldiv_state_e` (IDLE/CALC/FIN), `MULDIV_ITER` = 32.
- One sub-module, `muldiv_sign_fix`: combinational negate/word-select stage used in FIN.

## Test plan
- MUL 7 × −3 (0x0000_0007, 0xFFFF_FFFD) → `result` 0xFFFF_FFEB, `done` 33 cycles after start (1 with `MULDIV_FAST_MUL_EN`), `rd_out`=rd_in.
- MULH/MULHU/MULHSU on 0x8000_0000 × 0xFFFF_FFFF → 0x0000_0000 / 0x7FFF_FFFF / 0x8000_0000.
- DIV −7 / 2 → 0xFFFF_FFFD; REM → 0xFFFF_FFFF; DIVU 100/7 → 14; REMU → 2.
- Divide by zero: DIV 5/0 → 0xFFFF_FFFF, REM 5/0 → 5, `done` after 1 cycle; overflow 0x8000_0000 / −1 → 0x8000_0000, REM → 0.
- `kill` at iteration 10 → no `done`, `busy` low next cycle, `result` keeps prior value; `start` during CALC ignored.
- `rst_n` low mid-CALC → all outputs 0 immediately; back-to-back start in `done` cycle accepted with new rd.
